// File: rtl/calc_pkg.sv
// Shared types and constants for the 16-bit calculator front end.
// State encoding is chosen so the 3-bit debug phase is the low bits of the state code.
package calc_pkg;

  localparam int OPW  = 4;
  localparam int RESW = 16;

  // START is a one-cycle transient, so it is the state that aliases A_LO on the 3-bit phase.
  typedef enum logic [3:0] {
    A_LO    = 4'd0,
    A_HI    = 4'd1,
    B_LO    = 4'd2,
    B_HI    = 4'd3,
    OP      = 4'd4,
    EXEC    = 4'd5,
    SHOW_LO = 4'd6,
    SHOW_HI = 4'd7,
    START   = 4'd8
  } calc_state_e;

  localparam logic [OPW-1:0] OP_ADD = 4'd0;
  localparam logic [OPW-1:0] OP_SUB = 4'd1;
  localparam logic [OPW-1:0] OP_MUL = 4'd2;
  localparam logic [OPW-1:0] OP_DIV = 4'd3;
  localparam logic [OPW-1:0] OP_AND = 4'd4;
  localparam logic [OPW-1:0] OP_OR  = 4'd5;
  localparam logic [OPW-1:0] OP_XOR = 4'd6;

  function automatic logic [2:0] phase_of(input calc_state_e s);
    logic [3:0] code;
    code = s;
    return code[2:0];
  endfunction

endpackage

// File: rtl/calc_pad_sync.sv
// Multi-stage synchroniser for the pad byte, strobe and clear.
// Produces a one-cycle pulse on each rising edge of the synchronised strobe.
module calc_pad_sync #(
  parameter int STAGES = 2,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_i,
  input  logic         stb_i,
  input  logic         clear_i,
  output logic [W-1:0] data_o,
  output logic         stb_rise_o,
  output logic         clear_o
);

  // Bit W carries the strobe, bit W+1 the clear, so all pad inputs share one chain.
  logic [STAGES-1:0][W+1:0] sync_q;
  logic                     stb_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      stb_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {clear_i, stb_i, data_i};
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      stb_prev_q <= sync_q[STAGES-1][W];
    end
  end

  assign data_o     = sync_q[STAGES-1][W-1:0];
  assign stb_rise_o = sync_q[STAGES-1][W] & ~stb_prev_q;
  assign clear_o    = sync_q[STAGES-1][W+1];

endmodule

// File: rtl/calc_input_sequencer.sv
// Pad-side sequencer: loads operands and opcode byte by byte, runs the ALU
// handshake with a timeout, then presents the 16-bit result as two bytes.
module calc_input_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int OPW         = calc_pkg::OPW,
  parameter int TIMEOUT     = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     byte_in_i,
  input  logic           byte_stb_i,
  input  logic           clear_i,
  output logic [15:0]    op_a_o,
  output logic [15:0]    op_b_o,
  output logic [OPW-1:0] opcode_o,
  output logic           alu_start_o,
  input  logic           alu_done_i,
  input  logic [15:0]    alu_result_i,
  input  logic           alu_err_i,
  output logic [7:0]     byte_out_o,
  output logic           res_valid_o,
  output logic           err_o,
  output logic           busy_o,
  output logic [2:0]     phase_o
);

  import calc_pkg::*;

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [7:0] byte_s;
  logic       stb_ev;
  logic       clear_s;

  calc_pad_sync #(
    .STAGES (SYNC_STAGES),
    .W      (8)
  ) u_pad_sync (
    .clk        (clk),
    .rst        (rst),
    .data_i     (byte_in_i),
    .stb_i      (byte_stb_i),
    .clear_i    (clear_i),
    .data_o     (byte_s),
    .stb_rise_o (stb_ev),
    .clear_o    (clear_s)
  );

  calc_state_e    state_q, state_d;
  logic [15:0]    op_a_q, op_a_d;
  logic [15:0]    op_b_q, op_b_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [7:0]     res_hi_q, res_hi_d;
  logic [7:0]     byte_out_q, byte_out_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= A_LO;
      op_a_q     <= '0;
      op_b_q     <= '0;
      opcode_q   <= '0;
      res_hi_q   <= '0;
      byte_out_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      opcode_q   <= opcode_d;
      res_hi_q   <= res_hi_d;
      byte_out_q <= byte_out_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Clear outranks everything; the timeout fires as the counter steps onto TIMEOUT-1,
  // which puts the error exactly TIMEOUT cycles after the start pulse.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    opcode_d   = opcode_q;
    res_hi_d   = res_hi_q;
    byte_out_d = byte_out_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cnt_nxt    = cnt_q + 1'b1;

    if (clear_s) begin
      state_d  = A_LO;
      op_a_d   = '0;
      op_b_d   = '0;
      opcode_d = '0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        A_LO:    if (stb_ev) begin op_a_d[7:0]  = byte_s; state_d = A_HI; end
        A_HI:    if (stb_ev) begin op_a_d[15:8] = byte_s; state_d = B_LO; end
        B_LO:    if (stb_ev) begin op_b_d[7:0]  = byte_s; state_d = B_HI; end
        B_HI:    if (stb_ev) begin op_b_d[15:8] = byte_s; state_d = OP;   end
        OP:      if (stb_ev) begin opcode_d = byte_s[OPW-1:0]; state_d = START; end
        START: begin
          cnt_d      = '0;
          err_d      = 1'b0;
          byte_out_d = '0;
          state_d    = EXEC;
        end
        EXEC: begin
          if (alu_done_i) begin
            res_hi_d   = alu_result_i[15:8];
            byte_out_d = alu_result_i[7:0];
            err_d      = alu_err_i;
            state_d    = SHOW_LO;
          end else if (cnt_nxt == CNT_LAST) begin
            res_hi_d   = '0;
            byte_out_d = '0;
            err_d      = 1'b1;
            state_d    = SHOW_LO;
          end else begin
            cnt_d = cnt_nxt;
          end
        end
        SHOW_LO: if (stb_ev) begin byte_out_d = res_hi_q; state_d = SHOW_HI; end
        SHOW_HI: if (stb_ev) state_d = A_LO;
        default: state_d = A_LO;
      endcase
    end
  end

  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign opcode_o    = opcode_q;
  assign alu_start_o = (state_q == START);
  assign busy_o      = (state_q == EXEC);
  assign res_valid_o = (state_q == SHOW_LO) || (state_q == SHOW_HI);
  assign byte_out_o  = byte_out_q;
  assign err_o       = err_q;
  assign phase_o     = phase_of(state_q);

endmodule
